// File: rtl/stopwatch_lap.sv
// Decimal stopwatch with a prescaled tick, up/down counting and parallel binary/BCD counts.
// Define STOPWATCH_LAP_CAPTURE_EN to build the edge-triggered lap capture registers.
module stopwatch_lap #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 10,
  parameter int unsigned DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            tag,
  input  logic                  dir,
  output logic [31:0]           count,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [31:0]           lap,
  output logic                  lap_valid,
  output logic                  tick,
  output logic                  wrap,
  output logic                  running
);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  localparam logic [31:0] DIV = 32'(CLK_HZ / TICK_HZ);
  localparam logic [31:0] MAX = 32'(pow10(DIGITS) - 1);

  localparam logic [2:0] CMD_RUN   = 3'd1;
  localparam logic [2:0] CMD_CLEAR = 3'd2;
  localparam logic [2:0] CMD_LAP   = 3'd3;

  logic [31:0]          presc_q, presc_d;
  logic [31:0]          count_q, count_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic                 tick_q, tick_d;
  logic                 wrap_q, wrap_d;
  logic                 running_q;
  logic                 run_cmd;

  assign run_cmd = (tag == CMD_RUN) || (tag == CMD_LAP);

  // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    logic carry;
    presc_d = presc_q;
    count_d = count_q;
    bcd_d   = bcd_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    if (tag == CMD_CLEAR) begin
      presc_d = '0;
      count_d = '0;
      bcd_d   = '0;
    end else if (run_cmd) begin
      if (presc_q == DIV - 32'd1) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (!dir) begin
          wrap_d  = (count_q == MAX);
          count_d = wrap_d ? '0 : count_q + 32'd1;
        end else begin
          wrap_d  = (count_q == '0);
          count_d = wrap_d ? MAX : count_q - 32'd1;
        end
        // Digit ripple: all-nines rolls to all-zeros and vice versa, so wrap needs no special case.
        for (int i = 0; i < DIGITS; i++) begin
          if (carry) begin
            if (!dir) begin
              if (bcd_q[4*i +: 4] == 4'd9) bcd_d[4*i +: 4] = 4'd0;
              else begin
                bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                carry = 1'b0;
              end
            end else begin
              if (bcd_q[4*i +: 4] == 4'd0) bcd_d[4*i +: 4] = 4'd9;
              else begin
                bcd_d[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
                carry = 1'b0;
              end
            end
          end
        end
      end else begin
        presc_d = presc_q + 32'd1;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      bcd_q     <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      bcd_q     <= bcd_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      running_q <= run_cmd;
    end
  end

`ifdef STOPWATCH_LAP_CAPTURE_EN
  logic [31:0] lap_q;
  logic        lap_valid_q;
  logic        prev_lap_q;

  // Capture the pre-update count only on entry into the lap code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
      prev_lap_q  <= 1'b0;
    end else begin
      prev_lap_q <= (tag == CMD_LAP);
      if (tag == CMD_CLEAR) begin
        lap_valid_q <= 1'b0;
      end else if ((tag == CMD_LAP) && !prev_lap_q) begin
        lap_q       <= count_q;
        lap_valid_q <= 1'b1;
      end
    end
  end

  assign lap       = lap_q;
  assign lap_valid = lap_valid_q;
`else
  assign lap       = '0;
  assign lap_valid = 1'b0;
`endif

  assign count   = count_q;
  assign bcd     = bcd_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign running = running_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Randomized bench for stopwatch_lap against a cycle-level arithmetic model of the stopwatch.
// Lap expectations follow STOPWATCH_LAP_CAPTURE_EN as seen by this file.
`timescale 1ns/1ps
module tb_stopwatch_lap;

  localparam int DIV    = 10;
  localparam int DIGITS = 2;
  localparam int MAX    = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  tag;
  logic        dir;
  logic [31:0] count;
  logic [7:0]  bcd;
  logic [31:0] lap;
  logic        lap_valid, tick, wrap, running;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: decimal count value and cycles elapsed in the current tick interval.
  int m_cnt, m_phase, m_lap;
  bit m_lapv, m_prev3, m_tick, m_wrap, m_run;

  stopwatch_lap #(.CLK_HZ(100), .TICK_HZ(10), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .tag(tag), .dir(dir),
    .count(count), .bcd(bcd), .lap(lap), .lap_valid(lap_valid),
    .tick(tick), .wrap(wrap), .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) % 10) << 4 | (v % 10));
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_phase = 0; m_lap = 0;
    m_lapv = 0; m_prev3 = 0; m_tick = 0; m_wrap = 0; m_run = 0;
  endfunction

  function automatic void model_edge(input logic [2:0] t, input logic d);
    bit run_c;
    run_c  = (t == 3'd1) || (t == 3'd3);
    m_tick = 0;
    m_wrap = 0;
    m_run  = run_c;
`ifdef STOPWATCH_LAP_CAPTURE_EN
    if (t == 3'd3 && !m_prev3) begin
      m_lap  = m_cnt;
      m_lapv = 1;
    end
    if (t == 3'd2) m_lapv = 0;
    m_prev3 = (t == 3'd3);
`endif
    if (t == 3'd2) begin
      m_cnt   = 0;
      m_phase = 0;
    end else if (run_c) begin
      m_phase++;
      if (m_phase == DIV) begin
        m_phase = 0;
        m_tick  = 1;
        if (!d) begin
          m_wrap = (m_cnt == MAX);
          m_cnt  = (m_cnt + 1) % (MAX + 1);
        end else begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + MAX) % (MAX + 1);
        end
      end
    end
  endfunction

  task automatic compare_all();
    check("count", 64'(count), 64'(m_cnt));
    check("bcd", 64'(bcd), 64'(to_bcd(m_cnt)));
    check("tick", 64'(tick), 64'(m_tick));
    check("wrap", 64'(wrap), 64'(m_wrap));
    check("running", 64'(running), 64'(m_run));
    check("lap", 64'(lap), 64'(m_lap));
    check("lap_valid", 64'(lap_valid), 64'(m_lapv));
  endtask

  task automatic step(input logic [2:0] t, input logic d);
    @(negedge clk);
    tag = t;
    dir = d;
    @(posedge clk);
    model_edge(t, d);
    #1;
    compare_all();
  endtask

  task automatic steps(input int n, input logic [2:0] t, input logic d);
    for (int k = 0; k < n; k++) step(t, d);
  endtask

  // Called right after step(): pulse reset well clear of both clock edges.
  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tag = 3'd0;
    dir = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Three ticks from reset release, at cycles 10, 20, 30.
    steps(30, 3'd1, 1'b0);
    check("count_after_30", 64'(count), 64'd3);
    check("bcd_after_30", 64'(bcd), 64'h03);

    // Down from 0 wraps to 99, then 99 up wraps to 0, then down twice: 99, 98.
    step(3'd2, 1'b0);
    steps(10, 3'd1, 1'b1);
    check("down_wrap_count", 64'(count), 64'd99);
    check("down_wrap_bcd", 64'(bcd), 64'h99);
    check("down_wrap_pulse", 64'(wrap), 64'd1);
    steps(10, 3'd1, 1'b0);
    check("up_wrap_count", 64'(count), 64'd0);
    check("up_wrap_pulse", 64'(wrap & tick), 64'd1);
    step(3'd1, 1'b0);
    check("wrap_one_cycle", 64'(wrap), 64'd0);
    step(3'd2, 1'b0);
    steps(20, 3'd1, 1'b1);
    check("down_98", 64'(count), 64'd98);

    // Pause mid-interval keeps the prescaler; tick lands 6 running cycles after resume.
    step(3'd2, 1'b0);
    steps(50, 3'd1, 1'b0);
    check("count_5", 64'(count), 64'd5);
    steps(4, 3'd1, 1'b0);
    steps(50, 3'd0, 1'b0);
    check("paused_running", 64'(running), 64'd0);
    steps(5, 3'd1, 1'b0);
    check("no_tick_yet", 64'(tick), 64'd0);
    step(3'd1, 1'b0);
    check("resume_tick", 64'(tick), 64'd1);
    check("resume_count", 64'(count), 64'd6);

    // Lap capture held for 25 cycles, then clear.
    step(3'd2, 1'b0);
    steps(120, 3'd1, 1'b0);
    check("count_12", 64'(count), 64'd12);
    steps(25, 3'd3, 1'b0);
    check("lap_count_moved", 64'(count), 64'd14);
`ifdef STOPWATCH_LAP_CAPTURE_EN
    check("lap_12", 64'(lap), 64'd12);
    check("lap_valid_set", 64'(lap_valid), 64'd1);
`endif
    step(3'd2, 1'b0);
    check("clear_count", 64'(count), 64'd0);
    check("clear_lap_valid", 64'(lap_valid), 64'd0);
`ifdef STOPWATCH_LAP_CAPTURE_EN
    check("lap_retained", 64'(lap), 64'd12);
`endif

    // Asynchronous reset at count 47, mid-interval.
    steps(470, 3'd1, 1'b0);
    steps(3, 3'd3, 1'b0);
    check("count_47", 64'(count), 64'd47);
    async_reset();
    check("rst_count_zero", 64'(count), 64'd0);
    steps(12, 3'd1, 1'b0);

    // Randomized commands, directions and occasional resets.
    for (int k = 0; k < 2500; k++) begin
      int r;
      logic [2:0] t;
      r = $urandom_range(0, 15);
      if (r <= 8)       t = 3'd1;
      else if (r <= 10) t = 3'd3;
      else if (r == 11) t = 3'd2;
      else if (r == 12) t = 3'd0;
      else              t = 3'($urandom_range(4, 7));
      step(t, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap.md
STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL provide parameter TICK_HZ, default 10, count rate in Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2.
REQ-003 SHALL provide parameter DIGITS, default 4, range 1..8, decimal digits; MAX = 10^DIGITS - 1.
REQ-004 SHALL provide port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL provide port tag, input, 3, command: 1 run, 2 clear, 3 run+lap, all other codes pause.
REQ-007 SHALL provide port dir, input, 1, 0 count up, 1 count down; sampled on each tick.
REQ-008 SHALL provide port count, output, 32, binary count value.
REQ-009 SHALL provide port bcd, output, 4*DIGITS, BCD count, digit 0 in bits [3:0].
REQ-010 SHALL provide port lap, output, 32, last captured count.
REQ-011 SHALL provide port lap_valid, output, 1, high once lap holds a capture.
REQ-012 SHALL provide port tick, output, 1, one-cycle pulse per count update.
REQ-013 SHALL provide port wrap, output, 1, one-cycle pulse when count wraps.
REQ-014 SHALL provide port running, output, 1, registered: high while last sampled tag is 1 or 3.

Function
REQ-015 SHALL hold an internal prescaler, 32 bits, counting 0..DIV-1 only while tag is 1 or 3.
REQ-016 SHALL, on the edge where prescaler = DIV-1 while running, reset prescaler to 0, pulse tick and update count/bcd on that same edge (count visible one cycle later).
REQ-017 SHALL, under pause codes, freeze prescaler, count and bcd; resuming continues from the frozen prescaler value.
REQ-018 SHALL, when dir=0, increment; MAX -> 0 and pulse wrap on that tick.
REQ-019 SHALL, when dir=1, decrement; 0 -> MAX and pulse wrap on that tick.
REQ-020 SHALL keep bcd equal to the decimal form of count at all times, updated by per-digit ripple carry/borrow, no binary-to-BCD conversion.
REQ-021 SHALL, on tag=2, zero count, bcd, prescaler and lap_valid on the next edge; lap value is retained; tick and wrap stay low.
REQ-022 SHALL capture lap on the first edge where tag=3 after a cycle with tag!=3 (edge-detected); lap receives the count value present before that edge's update; lap_valid set to 1.
REQ-023 SHALL NOT recapture while tag remains 3; a new capture requires tag to leave 3 and return.
REQ-024 SHALL treat a dir change mid-interval as effective on the next tick only; prescaler is not disturbed.
REQ-025 SHALL keep count <= MAX in all states.

Reset
REQ-026 SHALL, while rst=1, force count=0, bcd=0, lap=0, lap_valid=0, tick=0, wrap=0, running=0, prescaler=0 and the lap edge-detect history to "not 3", independent of clk.
REQ-027 SHALL, when rst asserts mid-interval, discard the partial prescaler count; first tick after release occurs DIV running cycles later.

Configuration
REQ-028 SHALL, with macro STOPWATCH_LAP_CAPTURE_EN defined, implement lap, lap_valid and the edge-detect logic per REQ-022/023.
REQ-029 SHALL, without STOPWATCH_LAP_CAPTURE_EN, tie lap=0 and lap_valid=0, omit the capture registers, and treat tag=3 identically to tag=1.

Verification (CLK_HZ=100, TICK_HZ=10 -> DIV=10, DIGITS=2 -> MAX=99)
REQ-030 SHALL test: rst release, tag=1, dir=0 for 30 cycles -> tick pulses at cycles 10, 20, 30; count=3, bcd=8'h03.
REQ-031 SHALL test: count=99, dir=0, run to next tick -> count=0, bcd=8'h00, wrap and tick high for exactly that cycle.
REQ-032 SHALL test: count=0, dir=1, run one tick -> count=99, bcd=8'h99, wrap pulse; next tick -> 98.
REQ-033 SHALL test: count=5, run 4 cycles into interval, tag=0 for 50 cycles, tag=1 -> next tick after 6 more cycles, count=6.
REQ-034 SHALL test (macro defined): count=12, tag=3 held 25 cycles -> lap=12 captured once, lap_valid=1, count keeps incrementing; tag=2 -> count=0, lap_valid=0, lap=12.
REQ-035 SHALL test: rst pulsed asynchronously between clk edges with count=47 -> all outputs zero before next clk edge.
